result_tx_streamer: RTL
=======================

// Module: result_tx_streamer
// PURPOSE
//  Transmit-side counterpart of the USB receive path. Accepts 32-bit result words from the
//  computation unit, buffers them in a word FIFO, serializes them LSB-byte-first and writes
//  them row by row into the USB driver's transmit FIFO. Each row is committed with a
//  FIFO_tx_ready / FIFO_tx_BT block handshake. Sits between the computation unit and the
//  USB driver's transmit port.
// PARAMETERS
//  ROW_BYTES  426  data bytes per row (one USB block)
//  ROWS       240  rows per frame; ROW_BYTES*ROWS must be divisible by 4
//  FIFO_AW    4    word FIFO address width; depth = 2**FIFO_AW words
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  result_flat     in   32  result word; byte [7:0] is sent first, [31:24] last
//  result_valid    in   1   result_flat valid
//  result_ready    out  1   word FIFO not full; a word is accepted on valid&&ready
//  FIFO_tx_enable  out  1   one-cycle write strobe per byte to USB transmit FIFO
//  FIFO_tx_din     out  8   byte data, valid while FIFO_tx_enable=1
//  FIFO_tx_BT      in   1   driver block transfer in progress; no writes while high
//  FIFO_tx_ready   out  1   row complete, request block transfer (level)
//  frame_done      out  1   one-cycle pulse after the last row of a frame is transferred
//  tx_busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - outputs: FIFO_tx_enable=0, FIFO_tx_din=0, FIFO_tx_ready=0, frame_done=0, tx_busy=0.
//   - result_ready=1.
//   - word FIFO emptied; byte lane, byte count and row count cleared; state=IDLE.
//  Reset mid-row discards partial row data; there is no resume.
//  Word FIFO:
//   - result_ready = !full; no push while full, even when a pop occurs in the same cycle.
//   - Push and pop in the same cycle when not full are both honoured.
//  States:
//   - IDLE: go to SEND when the FIFO is non-empty.
//   - SEND: each cycle with FIFO_tx_BT=0 and a byte available:
//       - FIFO_tx_enable=1 and FIFO_tx_din=current lane byte; lane++.
//       - Leaving lane 3 pops the next word with no bubble.
//     If the FIFO is empty or FIFO_tx_BT=1, enable=0 (stall) and the state holds.
//     After byte ROW_BYTES-1 of the row: go to COMMIT. A word may straddle rows; its
//     remaining lanes carry into the next row.
//   - COMMIT: FIFO_tx_ready=1 until FIFO_tx_BT is sampled 1, then go to WAIT_BT.
//   - WAIT_BT: FIFO_tx_ready=0; wait for FIFO_tx_BT=0.
//       - Then if row==ROWS-1: row=0, frame_done pulses 1 cycle, go to IDLE.
//       - Else row++ and go to SEND.
//  Latency: word accepted at cycle N -> earliest FIFO_tx_enable at N+2; steady state is
//  1 byte/cycle.
//  Counters: byte counter is ceil(log2(ROW_BYTES+1)) bits; row counter ceil(log2(ROWS)) bits.
//   Both wrap only by explicit clear, never by overflow.
//  FIFO_tx_BT=1 during SEND pauses output; no byte is lost or duplicated.
// CONFIGURATION
//  TX_ROW_CHECKSUM_EN defined:
//   - After byte ROW_BYTES-1, one extra byte is sent in SEND before COMMIT: the XOR of
//     that row's ROW_BYTES data bytes. The checksum byte obeys the same BT stall rule.
//   - Row length on the wire = ROW_BYTES+1.
//   - The accumulator clears at row start.
//  Undefined: rows are exactly ROW_BYTES bytes; no checksum logic is present.
// TESTING (ROW_BYTES=8, ROWS=2, FIFO_AW=2 unless noted)
//  1. Push 0x03020100, 0x07060504 with BT=0 -> bytes 00..07 on 8 consecutive enables;
//     FIFO_tx_ready=1; pulse BT high 3 cycles -> ready drops on first BT=1 cycle.
//  2. Push 4 words 0x0..0x3-pattern, full frame with BT handshakes -> 16 bytes in order,
//     2 ready/BT handshakes, frame_done exactly 1 cycle after second BT falls.
//  3. Push 6 words back-to-back with no BT response -> result_ready=0 after 4 buffered
//     (minus pops); no word dropped; all bytes appear in order.
//  4. Hold BT=1 for 5 cycles mid-row after byte 3 -> enable=0 for those cycles; byte 4
//     appears on first cycle BT=0.
//  5. Assert rst_n=0 after byte 5 of row 0 -> all outputs at reset values next cycle;
//     new push 0xAABBCCDD sends DD first as row 0 byte 0.
//  6. TX_ROW_CHECKSUM_EN, row bytes 00..07 -> 9th byte = 0x00; bytes 01 01 01 01 02 02 02 02
//     -> 9th byte = 0x00; bytes 0xFF x4 + 00 x4 -> 0x00; 01,00x7 -> 0x01.

Source files
------------

// File: rtl/result_tx_streamer.sv
// Buffers 32-bit result words and streams them LSB-byte-first into the USB transmit FIFO,
// one row per block handshake. Optional per-row XOR checksum byte: TX_ROW_CHECKSUM_EN.
module result_tx_streamer #(
   parameter int ROW_BYTES = 426,
   parameter int ROWS      = 240,
   parameter int FIFO_AW   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] result_flat,
   input  logic        result_valid,
   output logic        result_ready,
   output logic        FIFO_tx_enable,
   output logic [7:0]  FIFO_tx_din,
   input  logic        FIFO_tx_BT,
   output logic        FIFO_tx_ready,
   output logic        frame_done,
   output logic        tx_busy
);

   localparam int DEPTH  = 2 ** FIFO_AW;
   localparam int BYTE_W = $clog2(ROW_BYTES + 1);
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, SEND, COMMIT, WAIT_BT} state_t;

   state_t state, next_state;

   logic [31:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               full, empty, push, pop;

   logic [1:0]         lane;
   logic [BYTE_W-1:0]  byte_cnt;
   logic [ROW_W-1:0]   row_cnt;
   logic [7:0]         lane_byte;
   logic [7:0]         csum;
   logic               csum_phase;
   logic               send_data, send_csum, row_end, last_row, bt_done;

   assign full         = (count == (FIFO_AW + 1)'(DEPTH));
   assign empty        = (count == '0);
   assign result_ready = !full;
   assign push         = result_valid && !full;
   assign pop          = send_data && (lane == 2'd3);

   always_comb begin
      lane_byte = 8'h00;
      case (lane)
         2'd0: lane_byte = mem[rd_ptr][7:0];
         2'd1: lane_byte = mem[rd_ptr][15:8];
         2'd2: lane_byte = mem[rd_ptr][23:16];
         2'd3: lane_byte = mem[rd_ptr][31:24];
         default: lane_byte = 8'h00;
      endcase
   end

`ifdef TX_ROW_CHECKSUM_EN
   // The checksum byte occupies slot ROW_BYTES and needs no FIFO data, only BT low.
   assign csum_phase = (byte_cnt == BYTE_W'(ROW_BYTES));
   assign row_end    = send_csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         csum <= 8'h00;
      else if (send_csum)
         csum <= 8'h00;
      else if (send_data)
         csum <= csum ^ lane_byte;
   end
`else
   assign csum_phase = 1'b0;
   assign row_end    = send_data && (byte_cnt == BYTE_W'(ROW_BYTES - 1));
   assign csum       = 8'h00;
`endif

   assign send_data = (state == SEND) && !FIFO_tx_BT && !csum_phase && !empty;
   assign send_csum = (state == SEND) && !FIFO_tx_BT && csum_phase;
   assign last_row  = (row_cnt == ROW_W'(ROWS - 1));
   assign bt_done   = (state == WAIT_BT) && !FIFO_tx_BT;

   // Storage has no reset; emptiness is defined by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= result_flat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Lane survives the row boundary so a straddling word continues in the next row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane       <= 2'd0;
         byte_cnt   <= '0;
         row_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= bt_done && last_row;
         if (send_data)
            lane <= lane + 2'd1;
         if (row_end)
            byte_cnt <= '0;
         else if (send_data)
            byte_cnt <= byte_cnt + BYTE_W'(1);
         if (bt_done)
            row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!empty)     next_state = SEND;
         SEND:    if (row_end)    next_state = COMMIT;
         COMMIT:  if (FIFO_tx_BT) next_state = WAIT_BT;
         WAIT_BT: if (!FIFO_tx_BT) next_state = last_row ? IDLE : SEND;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      FIFO_tx_enable = send_data || send_csum;
      FIFO_tx_din    = 8'h00;
      if (send_data)
         FIFO_tx_din = lane_byte;
      else if (send_csum)
         FIFO_tx_din = csum;
      FIFO_tx_ready  = (state == COMMIT) && !FIFO_tx_BT;
      tx_busy        = (state != IDLE);
   end

endmodule
